// File: rtl/jtframe_sdram_cmdseq.sv
// SDRAM command sequencer: bank/row tracking, ACTIVE/PRECHARGE/REFRESH
// scheduling and a CL-deep read-data strobe pipeline.
module jtframe_sdram_cmdseq #(
    parameter int CL   = 2,
    parameter int TRP  = 2,
    parameter int TRCD = 2,
    parameter int TRFC = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] addr,
    input  logic        we,
    input  logic        req,
    output logic        ack,
    output logic        dst,
    input  logic        rfsh,
    output logic        rfsh_ack,
    output logic [12:0] sdram_a,
    output logic [1:0]  sdram_ba,
    output logic        sdram_ncs,
    output logic        sdram_nras,
    output logic        sdram_ncas,
    output logic        sdram_nwe
);

    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;

    typedef enum logic [2:0] {
        IDLE, PRE, PRE_WAIT, ACT_WAIT, RW, REF_PRE_WAIT, REF_WAIT
    } state_t;

    state_t            state_q, state_nx;
    logic [2:0]        cnt_q, cnt_nx;
    logic [3:0]        cmd_q, cmd_nx;
    logic [12:0]       a_q, a_nx;
    logic [1:0]        ba_q, ba_nx;
    logic              ack_q, ack_nx;
    logic              dst_q, dst_nx;
    logic              rfsh_ack_q, rfsh_ack_nx;
    logic [3:0]        open_q, open_nx;
    logic [3:0][12:0]  row_q, row_nx;
    logic [CL-1:0]     pipe_q, pipe_nx;
    logic [CL:0]       pipe_sh;
    logic [23:0]       addr_q, addr_nx;
    logic              we_q, we_nx;

    logic [23:0]       cur_addr;
    logic              cur_we;
    logic [1:0]        cur_ba;
    logic [12:0]       cur_row;
    logic [8:0]        cur_col;
    logic              do_act, do_rw, do_ref;

    // In IDLE the live request is decoded; afterwards the latched copy.
    assign cur_addr = (state_q == IDLE) ? addr : addr_q;
    assign cur_we   = (state_q == IDLE) ? we   : we_q;
    assign cur_ba   = cur_addr[23:22];
    assign cur_row  = cur_addr[21:9];
    assign cur_col  = cur_addr[8:0];

    always_comb begin
        state_nx    = state_q;
        cnt_nx      = cnt_q;
        cmd_nx      = CMD_NOP;
        a_nx        = a_q;
        ba_nx       = ba_q;
        ack_nx      = 1'b0;
        rfsh_ack_nx = 1'b0;
        open_nx     = open_q;
        row_nx      = row_q;
        addr_nx     = addr_q;
        we_nx       = we_q;
        do_act      = 1'b0;
        do_rw       = 1'b0;
        do_ref      = 1'b0;

        case (state_q)
            IDLE: begin
                // The ack cycle is dead time: no new command right after RW.
                if (!ack_q) begin
                    if (rfsh) begin
                        if (|open_q) begin
                            cmd_nx   = CMD_PRE;
                            a_nx     = 13'h400;
                            ba_nx    = 2'b00;
                            open_nx  = '0;
                            state_nx = REF_PRE_WAIT;
                            cnt_nx   = 3'(TRP - 1);
                        end else begin
                            do_ref = 1'b1;
                        end
                    end else if (req) begin
                        addr_nx = addr;
                        we_nx   = we;
                        if (open_q[cur_ba] && row_q[cur_ba] == cur_row)
                            do_rw = 1'b1;
                        else if (open_q[cur_ba])
                            state_nx = PRE;
                        else
                            do_act = 1'b1;
                    end
                end
            end
            PRE: begin
                cmd_nx          = CMD_PRE;
                a_nx            = 13'h000;
                ba_nx           = cur_ba;
                open_nx[cur_ba] = 1'b0;
                state_nx        = PRE_WAIT;
                cnt_nx          = 3'(TRP - 1);
            end
            PRE_WAIT: begin
                if (cnt_q == 3'd0) do_act = 1'b1;
                else cnt_nx = cnt_q - 3'd1;
            end
            ACT_WAIT: begin
                if (cnt_q == 3'd0) state_nx = RW;
                else cnt_nx = cnt_q - 3'd1;
            end
            RW: do_rw = 1'b1;
            REF_PRE_WAIT: begin
                if (cnt_q == 3'd0) do_ref = 1'b1;
                else cnt_nx = cnt_q - 3'd1;
            end
            REF_WAIT: begin
                if (cnt_q == 3'd0) state_nx = IDLE;
                else cnt_nx = cnt_q - 3'd1;
            end
            default: state_nx = IDLE;
        endcase

        if (do_act) begin
            cmd_nx          = CMD_ACT;
            a_nx            = cur_row;
            ba_nx           = cur_ba;
            open_nx[cur_ba] = 1'b1;
            row_nx[cur_ba]  = cur_row;
            if (TRCD == 1) begin
                state_nx = RW;
            end else begin
                state_nx = ACT_WAIT;
                cnt_nx   = 3'(TRCD - 2);
            end
        end

        if (do_rw) begin
            cmd_nx   = cur_we ? CMD_WRITE : CMD_READ;
            a_nx     = {4'b0000, cur_col};
            ba_nx    = cur_ba;
            ack_nx   = 1'b1;
            state_nx = IDLE;
        end

        if (do_ref) begin
            cmd_nx      = CMD_REF;
            rfsh_ack_nx = 1'b1;
            open_nx     = '0;
            if (TRFC == 1) begin
                state_nx = IDLE;
            end else begin
                state_nx = REF_WAIT;
                cnt_nx   = 3'(TRFC - 2);
            end
        end

        // Read strobes keep shifting regardless of what the FSM does next.
        pipe_sh = {pipe_q, do_rw & ~cur_we};
        pipe_nx = pipe_sh[CL-1:0];
        dst_nx  = pipe_q[CL-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cmd_q      <= CMD_NOP;
            a_q        <= '0;
            ba_q       <= '0;
            ack_q      <= 1'b0;
            dst_q      <= 1'b0;
            rfsh_ack_q <= 1'b0;
            open_q     <= '0;
            row_q      <= '0;
            pipe_q     <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_nx;
            cnt_q      <= cnt_nx;
            cmd_q      <= cmd_nx;
            a_q        <= a_nx;
            ba_q       <= ba_nx;
            ack_q      <= ack_nx;
            dst_q      <= dst_nx;
            rfsh_ack_q <= rfsh_ack_nx;
            open_q     <= open_nx;
            row_q      <= row_nx;
            pipe_q     <= pipe_nx;
            addr_q     <= addr_nx;
            we_q       <= we_nx;
        end
    end

    assign ack      = ack_q;
    assign dst      = dst_q;
    assign rfsh_ack = rfsh_ack_q;
    assign sdram_a  = a_q;
    assign sdram_ba = ba_q;
    assign {sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe} = cmd_q;

endmodule
